// File: rtl/regpair_sequencer_pkg.sv
// Shared types for the register-pair sequencer: register selects, pair opcodes,
// pair codes, sequencer states and the pair-to-register map.
package regpair_sequencer_pkg;

  localparam int DataW = 8;
  localparam int PairW = 16;
  localparam int FlagW = 4;

  typedef enum logic [2:0] {
    REG_A    = 3'd0,
    REG_B    = 3'd1,
    REG_C    = 3'd2,
    REG_D    = 3'd3,
    REG_E    = 3'd4,
    REG_H    = 3'd5,
    REG_L    = 3'd6,
    REG_NONE = 3'd7
  } reg_sel_t;

  typedef enum logic [1:0] {
    OP_READ16 = 2'd0,
    OP_LOAD16 = 2'd1,
    OP_INC16  = 2'd2,
    OP_DEC16  = 2'd3
  } regpair_op_t;

  typedef enum logic [1:0] {
    PAIR_BC  = 2'd0,
    PAIR_DE  = 2'd1,
    PAIR_HL  = 2'd2,
    PAIR_INV = 2'd3
  } reg_pair_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    RESP  = 3'd4
  } regseq_state_t;

  function automatic reg_sel_t pair_hi(input reg_pair_t p);
    unique case (p)
      PAIR_BC: return REG_B;
      PAIR_DE: return REG_D;
      PAIR_HL: return REG_H;
      default: return REG_NONE;
    endcase
  endfunction

  function automatic reg_sel_t pair_lo(input reg_pair_t p);
    unique case (p)
      PAIR_BC: return REG_C;
      PAIR_DE: return REG_E;
      PAIR_HL: return REG_L;
      default: return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/regpair_sequencer_if.sv
// Bundle of request/response handshake, core-side controls and register-file
// side signals around the pair sequencer.
interface regpair_sequencer_if;
  import regpair_sequencer_pkg::*;

  logic             req_valid;
  logic             req_ready;
  regpair_op_t      req_op;
  reg_pair_t        req_pair;
  logic [PairW-1:0] req_data;

  logic             rsp_valid;
  logic [PairW-1:0] rsp_data;
  logic             rsp_err;
  logic             rsp_zero;

  logic             core_stall;
  reg_sel_t         core_sel_a;
  reg_sel_t         core_sel_b;
  logic             core_load_en;
  logic [DataW-1:0] core_reg_input;
  logic [FlagW-1:0] core_flags_in;

  reg_sel_t         rf_reg_sel_a;
  reg_sel_t         rf_reg_sel_b;
  logic             rf_load_en;
  logic [DataW-1:0] rf_reg_input;
  logic [FlagW-1:0] rf_flags_in;
  logic [DataW-1:0] rf_reg_out_a;
  logic [DataW-1:0] rf_reg_out_b;
  logic [FlagW-1:0] rf_flags;

  modport slave (
    input  req_valid, req_op, req_pair, req_data,
    input  core_sel_a, core_sel_b, core_load_en, core_reg_input, core_flags_in,
    input  rf_reg_out_a, rf_reg_out_b, rf_flags,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_zero, core_stall,
    output rf_reg_sel_a, rf_reg_sel_b, rf_load_en, rf_reg_input, rf_flags_in
  );

  modport master (
    output req_valid, req_op, req_pair, req_data,
    output core_sel_a, core_sel_b, core_load_en, core_reg_input, core_flags_in,
    output rf_reg_out_a, rf_reg_out_b, rf_flags,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_zero, core_stall,
    input  rf_reg_sel_a, rf_reg_sel_b, rf_load_en, rf_reg_input, rf_flags_in
  );

endinterface

// File: rtl/regpair_sequencer.sv
// Expands one 16-bit pair request into 8-bit register-file cycles; forwards core
// controls while idle. Define REGSEQ_ZERO_FLAG_EN to report zero results of INC16/DEC16.
module regpair_sequencer
  import regpair_sequencer_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  regpair_sequencer_if.slave  bus
);

  regseq_state_t    r_state;
  regpair_op_t      r_op;
  reg_pair_t        r_pair;
  logic [PairW-1:0] r_result;
  logic             r_ready;
  logic             r_stall;
  logic             r_rspValid;
  logic [PairW-1:0] r_rspData;
  logic             r_rspErr;
  logic             r_rspZero;

  reg_sel_t         w_hiSel;
  reg_sel_t         w_loSel;
  logic [PairW-1:0] w_readValue;
  logic [PairW-1:0] w_readResult;
  logic             w_zeroHit;

  assign w_hiSel     = pair_hi(r_pair);
  assign w_loSel     = pair_lo(r_pair);
  assign w_readValue = {bus.rf_reg_out_b, bus.rf_reg_out_a};

  always_comb begin
    w_readResult = w_readValue;
    unique case (r_op)
      OP_INC16: w_readResult = w_readValue + 16'd1;
      OP_DEC16: w_readResult = w_readValue - 16'd1;
      default:  w_readResult = w_readValue;
    endcase
  end

`ifdef REGSEQ_ZERO_FLAG_EN
  assign w_zeroHit = (r_result == '0) && ((r_op == OP_INC16) || (r_op == OP_DEC16));
`else
  assign w_zeroHit = 1'b0;
`endif

  // Once busy, the sequencer owns the file: core writes are dropped and F is
  // fed back to itself because the file latches flags_in every cycle.
  always_comb begin
    bus.rf_reg_sel_a = bus.core_sel_a;
    bus.rf_reg_sel_b = bus.core_sel_b;
    bus.rf_load_en   = bus.core_load_en;
    bus.rf_reg_input = bus.core_reg_input;
    bus.rf_flags_in  = bus.core_flags_in;
    if (r_state != IDLE) begin
      bus.rf_reg_sel_a = w_loSel;
      bus.rf_reg_sel_b = w_hiSel;
      bus.rf_load_en   = 1'b0;
      bus.rf_reg_input = r_result[DataW-1:0];
      bus.rf_flags_in  = bus.rf_flags;
      if (r_state == WR_LO) begin
        bus.rf_load_en = 1'b1;
      end else if (r_state == WR_HI) begin
        bus.rf_reg_sel_a = w_hiSel;
        bus.rf_load_en   = 1'b1;
        bus.rf_reg_input = r_result[PairW-1:DataW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= OP_READ16;
      r_pair     <= PAIR_BC;
      r_result   <= '0;
      r_ready    <= 1'b1;
      r_stall    <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
      r_rspZero  <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspErr   <= 1'b0;
      r_rspZero  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_op    <= bus.req_op;
            r_pair  <= bus.req_pair;
            r_ready <= 1'b0;
            r_stall <= 1'b1;
            if (bus.req_pair == PAIR_INV) begin
              r_result   <= '0;
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_state    <= RESP;
            end else if (bus.req_op == OP_LOAD16) begin
              r_result <= bus.req_data;
              r_state  <= WR_LO;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          r_result <= w_readResult;
          if (r_op == OP_READ16) begin
            r_rspValid <= 1'b1;
            r_rspData  <= w_readResult;
            r_state    <= RESP;
          end else begin
            r_state <= WR_LO;
          end
        end
        WR_LO: r_state <= WR_HI;
        WR_HI: begin
          r_rspValid <= 1'b1;
          r_rspData  <= r_result;
          r_rspZero  <= w_zeroHit;
          r_state    <= RESP;
        end
        RESP: begin
          r_ready <= 1'b1;
          r_stall <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_stall <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.core_stall = r_stall;
  assign bus.rsp_valid  = r_rspValid;
  assign bus.rsp_data   = r_rspData;
  assign bus.rsp_err    = r_rspErr;
  assign bus.rsp_zero   = r_rspZero;

endmodule

// File: tb/tb_regpair_sequencer.sv
// Self-checking bench for regpair_sequencer with a behavioural register file
// and a pair-level reference model of the expected file contents.
module tb_regpair_sequencer;
  import regpair_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regpair_sequencer_if bus ();

  regpair_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in register file: one write port on sel_a, flags latched every cycle
  logic [7:0] rfRegs [8];
  logic [3:0] rfFlagReg;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rfRegs[i] <= 8'h00;
      rfFlagReg <= 4'h0;
    end else begin
      if (bus.rf_load_en) rfRegs[bus.rf_reg_sel_a] <= bus.rf_reg_input;
      rfFlagReg <= bus.rf_flags_in;
    end
  end
  assign bus.rf_reg_out_a = rfRegs[bus.rf_reg_sel_a];
  assign bus.rf_reg_out_b = rfRegs[bus.rf_reg_sel_b];
  assign bus.rf_flags     = rfFlagReg;

  // Reference model: register contents indexed A,B,C,D,E,H,L = 0..6
  logic [7:0] modelRegs [8];
  int hiMap [3] = '{1, 3, 5};
  int loMap [3] = '{2, 4, 6};
  int passCount = 0;
  int checkCount = 0;

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) modelRegs[i] = 8'h00;
  endfunction

  function automatic void modelRequest(input int op, input int pair, input logic [15:0] data,
                                       output logic [15:0] expData, output bit expErr,
                                       output bit expZero, output int expLat);
    logic [15:0] cur;
    logic [15:0] res;
    expZero = 1'b0;
    if (pair == 3) begin
      expData = 16'h0000; expErr = 1'b1; expLat = 1;
      return;
    end
    cur = {modelRegs[hiMap[pair]], modelRegs[loMap[pair]]};
    case (op)
      0:       res = cur;
      1:       res = data;
      2:       res = cur + 16'd1;
      default: res = cur - 16'd1;
    endcase
    expData = res;
    expErr  = 1'b0;
    expLat  = (op == 0) ? 2 : (op == 1) ? 3 : 4;
`ifdef REGSEQ_ZERO_FLAG_EN
    if (op >= 2 && res == 16'h0000) expZero = 1'b1;
`endif
    if (op != 0) begin
      modelRegs[hiMap[pair]] = res[15:8];
      modelRegs[loMap[pair]] = res[7:0];
    end
  endfunction

  task automatic writeReg(input int sel, input logic [7:0] val);
    bus.core_sel_a     = reg_sel_t'(sel[2:0]);
    bus.core_reg_input = val;
    bus.core_load_en   = 1'b1;
    @(posedge clk); #1;
    bus.core_load_en   = 1'b0;
    modelRegs[sel] = val;
  endtask

  // Issues one request and records what the DUT did until its response
  task automatic applyStimulus(input int op, input int pair, input logic [15:0] data, input bit noisy,
                               output logic [15:0] gotData, output bit gotErr, output bit gotZero,
                               output int gotLat, output int stallCycles, output bit sawLoad,
                               output bit flagsHeld, output logic readyAtResp);
    logic [3:0] heldFlags;
    int waitCnt;
    gotData = 16'h0; gotErr = 0; gotZero = 0; gotLat = -1;
    stallCycles = 0; sawLoad = 0; flagsHeld = 1; readyAtResp = 1'bx;
    waitCnt = 0;
    while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
      @(posedge clk); #1; waitCnt++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = regpair_op_t'(op[1:0]);
    bus.req_pair  = reg_pair_t'(pair[1:0]);
    bus.req_data  = data;
    heldFlags     = bus.core_flags_in;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (noisy) begin
        bus.core_load_en   = 1'b1;
        bus.core_sel_a     = REG_A;
        bus.core_reg_input = 8'h55;
        bus.core_flags_in  = 4'($urandom);
      end
      #1;
      if (bus.core_stall === 1'b1) stallCycles++;
      if (bus.rf_load_en === 1'b1) sawLoad = 1;
      if (bus.rf_flags !== heldFlags) flagsHeld = 0;
      if (bus.rsp_valid === 1'b1) begin
        gotLat = c; gotData = bus.rsp_data; gotErr = bus.rsp_err;
        gotZero = bus.rsp_zero; readyAtResp = bus.req_ready;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.core_load_en  = 1'b0;
    bus.core_flags_in = heldFlags;
  endtask

  logic [15:0] gotData, expData;
  bit gotErr, gotZero, sawLoad, flagsHeld, expErr, expZero;
  int gotLat, expLat, stallCycles;
  logic readyAtResp;

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 0; bus.req_op = OP_READ16; bus.req_pair = PAIR_BC; bus.req_data = 16'h0;
    bus.core_sel_a = REG_A; bus.core_sel_b = REG_A; bus.core_load_en = 0;
    bus.core_reg_input = 8'h00; bus.core_flags_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    modelReset();
    checkCount++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", bus.req_ready); else passCount++;
    checkCount++; if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else passCount++;
    checkCount++; if (bus.rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp_err: got %b want 0", bus.rsp_err); else passCount++;
    checkCount++; if (bus.rsp_zero !== 1'b0) $display("[TB] FAIL reset_rsp_zero: got %b want 0", bus.rsp_zero); else passCount++;
    checkCount++; if (bus.rsp_data !== 16'h0) $display("[TB] FAIL reset_rsp_data: got %h want 0000", bus.rsp_data); else passCount++;
    checkCount++; if (bus.core_stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", bus.core_stall); else passCount++;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.core_sel_a = REG_D; bus.core_sel_b = REG_H; bus.core_load_en = 1'b1;
    bus.core_reg_input = 8'hA7; bus.core_flags_in = 4'h9;
    #1;
    checkCount++; if (bus.rf_reg_sel_a !== REG_D) $display("[TB] FAIL pass_sel_a: got %0d want %0d", bus.rf_reg_sel_a, REG_D); else passCount++;
    checkCount++; if (bus.rf_reg_sel_b !== REG_H) $display("[TB] FAIL pass_sel_b: got %0d want %0d", bus.rf_reg_sel_b, REG_H); else passCount++;
    checkCount++; if (bus.rf_load_en !== 1'b1) $display("[TB] FAIL pass_load_en: got %b want 1", bus.rf_load_en); else passCount++;
    checkCount++; if (bus.rf_reg_input !== 8'hA7) $display("[TB] FAIL pass_reg_input: got %h want a7", bus.rf_reg_input); else passCount++;
    checkCount++; if (bus.rf_flags_in !== 4'h9) $display("[TB] FAIL pass_flags_in: got %h want 9", bus.rf_flags_in); else passCount++;
    bus.core_load_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load16();
    modelRequest(1, 2, 16'hBEEF, expData, expErr, expZero, expLat);
    applyStimulus(1, 2, 16'hBEEF, 0, gotData, gotErr, gotZero, gotLat, stallCycles, sawLoad, flagsHeld, readyAtResp);
    checkCount++; if (gotLat !== 3) $display("[TB] FAIL load16_latency: got %0d want 3", gotLat); else passCount++;
    checkCount++; if (gotData !== 16'hBEEF) $display("[TB] FAIL load16_data: got %h want beef", gotData); else passCount++;
    checkCount++; if (gotErr !== 1'b0) $display("[TB] FAIL load16_err: got %b want 0", gotErr); else passCount++;
    checkCount++; if (stallCycles !== 3) $display("[TB] FAIL load16_stall: got %0d want 3", stallCycles); else passCount++;
    checkCount++; if (rfRegs[5] !== 8'hBE) $display("[TB] FAIL load16_H: got %h want be", rfRegs[5]); else passCount++;
    checkCount++; if (rfRegs[6] !== 8'hEF) $display("[TB] FAIL load16_L: got %h want ef", rfRegs[6]); else passCount++;
  endtask

  task automatic test_inc16_busy_core();
    bus.core_flags_in = 4'hA;
    writeReg(0, 8'h33);
    writeReg(1, 8'h12);
    writeReg(2, 8'hFF);
    modelRequest(2, 0, 16'h0, expData, expErr, expZero, expLat);
    applyStimulus(2, 0, 16'h0, 1, gotData, gotErr, gotZero, gotLat, stallCycles, sawLoad, flagsHeld, readyAtResp);
    checkCount++; if (gotLat !== 4) $display("[TB] FAIL inc16_latency: got %0d want 4", gotLat); else passCount++;
    checkCount++; if (gotData !== 16'h1300) $display("[TB] FAIL inc16_data: got %h want 1300", gotData); else passCount++;
    checkCount++; if (rfRegs[1] !== 8'h13) $display("[TB] FAIL inc16_B: got %h want 13", rfRegs[1]); else passCount++;
    checkCount++; if (rfRegs[2] !== 8'h00) $display("[TB] FAIL inc16_C: got %h want 00", rfRegs[2]); else passCount++;
    checkCount++; if (flagsHeld !== 1'b1) $display("[TB] FAIL inc16_flags_held: got %b want 1", flagsHeld); else passCount++;
    checkCount++; if (rfRegs[0] !== 8'h33) $display("[TB] FAIL busy_write_dropped: got A=%h want 33", rfRegs[0]); else passCount++;
    writeReg(0, 8'h55);
    checkCount++; if (rfRegs[0] !== 8'h55) $display("[TB] FAIL idle_write: got A=%h want 55", rfRegs[0]); else passCount++;
  endtask

  task automatic test_dec16_wrap();
    writeReg(3, 8'h00);
    writeReg(4, 8'h00);
    modelRequest(3, 1, 16'h0, expData, expErr, expZero, expLat);
    applyStimulus(3, 1, 16'h0, 0, gotData, gotErr, gotZero, gotLat, stallCycles, sawLoad, flagsHeld, readyAtResp);
    checkCount++; if (gotData !== 16'hFFFF) $display("[TB] FAIL dec16_wrap_data: got %h want ffff", gotData); else passCount++;
    checkCount++; if (rfRegs[3] !== 8'hFF || rfRegs[4] !== 8'hFF) $display("[TB] FAIL dec16_wrap_DE: got %h%h want ffff", rfRegs[3], rfRegs[4]); else passCount++;
    checkCount++; if (gotZero !== 1'b0) $display("[TB] FAIL dec16_wrap_zero: got %b want 0", gotZero); else passCount++;
    writeReg(3, 8'h00);
    writeReg(4, 8'h01);
    modelRequest(3, 1, 16'h0, expData, expErr, expZero, expLat);
    applyStimulus(3, 1, 16'h0, 0, gotData, gotErr, gotZero, gotLat, stallCycles, sawLoad, flagsHeld, readyAtResp);
    checkCount++; if (gotData !== 16'h0000) $display("[TB] FAIL dec16_to_zero_data: got %h want 0000", gotData); else passCount++;
    checkCount++; if (gotZero !== expZero) $display("[TB] FAIL dec16_to_zero_flag: got %b want %b", gotZero, expZero); else passCount++;
  endtask

  task automatic test_invalid_pair();
    for (int op = 0; op < 4; op++) begin
      modelRequest(op, 3, 16'($urandom), expData, expErr, expZero, expLat);
      applyStimulus(op, 3, 16'($urandom), 0, gotData, gotErr, gotZero, gotLat, stallCycles, sawLoad, flagsHeld, readyAtResp);
      checkCount++; if (gotLat !== 1) $display("[TB] FAIL invalid_latency op%0d: got %0d want 1", op, gotLat); else passCount++;
      checkCount++; if (gotErr !== 1'b1) $display("[TB] FAIL invalid_err op%0d: got %b want 1", op, gotErr); else passCount++;
      checkCount++; if (gotData !== 16'h0) $display("[TB] FAIL invalid_data op%0d: got %h want 0000", op, gotData); else passCount++;
      checkCount++; if (sawLoad !== 1'b0) $display("[TB] FAIL invalid_no_write op%0d: got %b want 0", op, sawLoad); else passCount++;
    end
    for (int r = 0; r < 7; r++) begin
      checkCount++; if (rfRegs[r] !== modelRegs[r]) $display("[TB] FAIL invalid_regs r%0d: got %h want %h", r, rfRegs[r], modelRegs[r]); else passCount++;
    end
  endtask

  task automatic test_reset_mid_op();
    bit sawRsp;
    bus.req_valid = 1'b1; bus.req_op = OP_LOAD16; bus.req_pair = PAIR_BC; bus.req_data = 16'hA55A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    modelReset();
    checkCount++; if (bus.req_ready !== 1'b1) $display("[TB] FAIL midreset_ready: got %b want 1", bus.req_ready); else passCount++;
    checkCount++; if (bus.core_stall !== 1'b0) $display("[TB] FAIL midreset_stall: got %b want 0", bus.core_stall); else passCount++;
    rst = 1'b0;
    sawRsp = bus.rsp_valid;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) sawRsp = 1;
    end
    checkCount++; if (sawRsp !== 1'b0) $display("[TB] FAIL midreset_no_rsp: got %b want 0", sawRsp); else passCount++;
    modelRequest(0, 0, 16'h0, expData, expErr, expZero, expLat);
    applyStimulus(0, 0, 16'h0, 0, gotData, gotErr, gotZero, gotLat, stallCycles, sawLoad, flagsHeld, readyAtResp);
    checkCount++; if (gotData !== 16'h0000) $display("[TB] FAIL midreset_read_bc: got %h want 0000", gotData); else passCount++;
    checkCount++; if (gotLat !== 2) $display("[TB] FAIL read16_latency: got %0d want 2", gotLat); else passCount++;
  endtask

  task automatic test_random_back_to_back();
    int op, pair;
    logic [15:0] data;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) writeReg($urandom_range(0, 6), 8'($urandom));
      op   = $urandom_range(0, 3);
      pair = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      data = 16'($urandom);
      modelRequest(op, pair, data, expData, expErr, expZero, expLat);
      applyStimulus(op, pair, data, 1'($urandom_range(0, 1)), gotData, gotErr, gotZero, gotLat,
                    stallCycles, sawLoad, flagsHeld, readyAtResp);
      checkCount++; if (gotLat !== expLat) $display("[TB] FAIL rand%0d_latency: got %0d want %0d", n, gotLat, expLat); else passCount++;
      checkCount++; if (gotData !== expData) $display("[TB] FAIL rand%0d_data: got %h want %h", n, gotData, expData); else passCount++;
      checkCount++; if (gotErr !== expErr) $display("[TB] FAIL rand%0d_err: got %b want %b", n, gotErr, expErr); else passCount++;
      checkCount++; if (gotZero !== expZero) $display("[TB] FAIL rand%0d_zero: got %b want %b", n, gotZero, expZero); else passCount++;
      checkCount++; if (readyAtResp !== 1'b0) $display("[TB] FAIL rand%0d_ready_in_resp: got %b want 0", n, readyAtResp); else passCount++;
      checkCount++; if (flagsHeld !== 1'b1) $display("[TB] FAIL rand%0d_flags_held: got %b want 1", n, flagsHeld); else passCount++;
    end
    for (int r = 0; r < 7; r++) begin
      checkCount++; if (rfRegs[r] !== modelRegs[r]) $display("[TB] FAIL rand_regs r%0d: got %h want %h", r, rfRegs[r], modelRegs[r]); else passCount++;
    end
  endtask

  initial begin
    $display("[TB] starting regpair_sequencer bench");
    test_reset();
    test_load16();
    test_inc16_busy_core();
    test_dec16_wrap();
    test_invalid_pair();
    test_reset_mid_op();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/regpair_sequencer.md
Name: regpair_sequencer

Overview:
- Controller in front of `register_file`. It owns that block's select, load, write-data and flag inputs.
- Turns one 16-bit register-pair request (BC/DE/HL: READ16, LOAD16, INC16, DEC16) into a fixed sequence of 8-bit register-file cycles. The file has one 8-bit write port and two read ports.
- While idle it forwards the core's register-file controls unchanged.
- While busy it stalls the core and holds flags stable, because the file latches `flags_in` every cycle.

Parameters:
- None. Data width is fixed at 8 and pair width at 16 by the architecture.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pair request valid
- req_ready  out  1  high only in IDLE
- req_op  in  2  regpair_op_t: READ16=0, LOAD16=1, INC16=2, DEC16=3
- req_pair  in  2  reg_pair_t: BC=0, DE=1, HL=2, 3=invalid
- req_data  in  16  LOAD16 value, {hi,lo}
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  16  final pair value; 0 on error
- rsp_err  out  1  valid with rsp_valid; invalid pair code
- rsp_zero  out  1  see Optional Feature
- core_stall  out  1  high when state != IDLE
- core_sel_a, core_sel_b  in  reg_sel_t  core's selects
- core_load_en  in  1  core write enable
- core_reg_input  in  8  core write data
- core_flags_in  in  4  core next flags
- rf_reg_sel_a, rf_reg_sel_b  out  reg_sel_t  to the file's reg_selA/reg_selB
- rf_load_en  out  1
- rf_reg_input  out  8
- rf_flags_in  out  4
- rf_reg_out_a, rf_reg_out_b  in  8  file read data
- rf_flags  in  4  file's current flags

Behaviour:
- Clocking: single clock `clk`. `rst` is synchronous and active-high; no asynchronous reset path.
- Reset values: state=IDLE; latched op/pair/data/result=0. Outputs: rsp_valid=0, rsp_err=0, rsp_zero=0, rsp_data=0, req_ready=1, core_stall=0.
- Pass-through (IDLE): rf_* outputs equal the matching core_* inputs combinationally; rf_flags_in=core_flags_in.
- Busy (any state other than IDLE):
  - core_load_en is ignored.
  - rf_flags_in=rf_flags, so F is held.
  - rf_reg_sel_b=hi register of the latched pair unless stated otherwise.
- Pair map (hi/lo): BC=B/C, DE=D/E, HL=H/L.
- IDLE:
  - Accept on req_valid&&req_ready and latch op, pair and data.
  - Next state: invalid pair -> RESP with err; LOAD16 -> WR_LO with result=req_data; any other op -> READ.
  - The core's controls are still forwarded in the accept cycle.
- READ:
  - Drive sel_a=lo, sel_b=hi, load_en=0.
  - Capture t={rf_reg_out_b, rf_reg_out_a}.
  - result: READ16 -> t; INC16 -> t+1 mod 2^16; DEC16 -> t-1 mod 2^16.
  - Next state: READ16 -> RESP; INC16/DEC16 -> WR_LO.
- WR_LO: sel_a=lo, load_en=1, reg_input=result[7:0]. Next WR_HI.
- WR_HI: sel_a=hi, load_en=1, reg_input=result[15:8]. Next RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_data=result; rsp_err set as latched.
  - req_ready=0. Next IDLE.
- Latency, from accept edge to rsp_valid cycle: READ16=2, LOAD16=3, INC16/DEC16=4, invalid=1. Back-to-back requests are accepted no sooner than the cycle after RESP.
- Wrap-around: INC16 of 0xFFFF gives 0x0000; DEC16 of 0x0000 gives 0xFFFF. Flags are never modified.
- Invalid pair: no register-file write and no read cycle; rsp_data=0, rsp_err=1.
- Reset mid-operation:
  - The sequencer returns to IDLE immediately and no rsp_valid is issued.
  - A low byte already written stays written; the register file shares `rst` and is cleared anyway.
- Simultaneous core_load_en during busy: dropped. The core must honour core_stall.

Optional Feature:
- Macro: REGSEQ_ZERO_FLAG_EN.
- Defined: rsp_zero = (result==16'h0000) during RESP for INC16 and DEC16, for the loop-count helper. It is 0 for READ16, LOAD16 and error responses.
- Not defined: the rsp_zero port still exists and is tied to 0.
- In both cases the F register is not affected.

Decomposition:
- Shared package (alongside reg_sel_t in the constants file):
  - regpair_op_t and reg_pair_t enums.
  - regseq_state_t {IDLE, READ, WR_LO, WR_HI, RESP}.
  - Functions pair_hi(reg_pair_t) and pair_lo(reg_pair_t), each returning reg_sel_t.
- No sub-module. It is one FSM plus a 16-bit incrementer/decrementer and an output mux.

Test Plan:
- LOAD16 HL=0xBEEF -> file H=0xBE, L=0xEF; rsp_valid 3 cycles after accept, rsp_data=0xBEEF; core_stall high for 3 cycles.
- Preload B=0x12, C=0xFF; INC16 BC -> B=0x13, C=0x00, rsp_data=0x1300. rf_flags unchanged while core_flags_in toggles during busy.
- DE=0x0000; DEC16 DE -> 0xFFFF. With REGSEQ_ZERO_FLAG_EN: DE=0x0001, DEC16 -> rsp_zero=1.
- req_pair=3 -> rsp_valid 1 cycle after accept with rsp_err=1, rsp_data=0; no rf_load_en pulse seen.
- core_load_en=1, core_sel_a=A, core_reg_input=0x55 issued during INC16 busy -> A unchanged; same command while IDLE -> A=0x55.
- rst asserted in WR_HI of LOAD16 BC=0xA55A -> next cycle IDLE, req_ready=1, no rsp_valid; next READ16 BC returns 0x0000.
